ram_rd_streamer: RTL and testbench

Read-sequencing controller for the wide (256-bit) read port of the shared activation/weight RAM. Once started with a base address, byte stride and beat count, it issues one wide read per cycle and delivers the returned words as a valid/ready stream to the downstream compute array. A 2-entry output buffer with credit-based issue absorbs back-pressure without losing beats. It replaces ad-hoc address counters in the compute-side load path.

---
 rtl/ram_rd_streamer.sv | 154 +++++++++++++++
 tb/tb_ram_rd_streamer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_streamer.sv
// Read-sequencing controller for the 256-bit wide RAM read port: issues strided
// reads and streams the returned words through a 2-entry credit-managed buffer.
module ram_rd_streamer #(
    parameter int addrWidth  = 32,
    parameter int dataWidth  = 256,
    parameter int countWidth = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start_i,
    input  logic [addrWidth-1:0]  base_addr_i,
    input  logic [addrWidth-1:0]  stride_i,
    input  logic [countWidth-1:0] count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [addrWidth-1:0]  rd_addr_o,
    input  logic [dataWidth-1:0]  rd_data_i,
    output logic [dataWidth-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  done_q;
    logic                  done_nxt;
    logic                  issue;

    logic [addrWidth-1:0]  addr;
    logic [addrWidth-1:0]  stride_q;
    logic [addrWidth-1:0]  last_addr;
    logic [countWidth-1:0] count_q;
    logic [countWidth-1:0] idx;
    logic                  inflight;

    logic [dataWidth-1:0]  fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_cnt;
    logic [1:0]            fifo_cnt_nxt;
    logic                  push;
    logic                  pop;
    logic                  credit_ok;

    assign pop          = valid_o & ready_i;
    assign push         = inflight;
    assign fifo_cnt_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};

    // A slot is free when buffered plus in-flight beats leave room, counting a pop this cycle.
    assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, inflight}) <= ({2'b00, pop} + 3'd1);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (count_i == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (idx == count_q - countWidth'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight && fifo_cnt_nxt == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr      <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            idx       <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == IDLE && start_i) begin
                addr     <= base_addr_i;
                stride_q <= stride_i;
                count_q  <= count_i;
                idx      <= '0;
            end else if (issue) begin
                addr      <= addr + stride_q;
                idx       <= idx + countWidth'(1);
                last_addr <= addr;
            end
        end
    end

    // When full, a simultaneous pop frees the head slot that the write pointer targets.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rd_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;
    assign rd_en_o   = issue;
    assign rd_addr_o = issue ? addr : last_addr;
    assign valid_o   = (fifo_cnt != 2'd0);
    assign data_o    = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed and randomized-ready checks of ram_rd_streamer against a simple RAM
// model whose word is a fixed function of the read address.
module tb_ram_rd_streamer;

    logic         clk;
    logic         nrst;
    logic         start_i;
    logic [31:0]  base_addr_i;
    logic [31:0]  stride_i;
    logic [15:0]  count_i;
    logic         busy_o;
    logic         done_o;
    logic         rd_en_o;
    logic [31:0]  rd_addr_o;
    logic [255:0] rd_data_i;
    logic [255:0] data_o;
    logic         valid_o;
    logic         ready_i;

    int n_assert;
    int n_fail;

    ram_rd_streamer #(
        .addrWidth (32),
        .dataWidth (256),
        .countWidth(16)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .stride_i   (stride_i),
        .count_i    (count_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_en_o    (rd_en_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    // RAM model: one-cycle read latency
    initial rd_data_i = '0;
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= pat(rd_addr_o);
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [31:0] base, input logic [31:0] stride,
                                 input logic [15:0] cnt, input logic rdy);
        @(posedge clk);
        #1;
        start_i     = st;
        base_addr_i = base;
        stride_i    = stride;
        count_i     = cnt;
        ready_i     = rdy;
        #2;
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_rd_en"}, rd_en_o, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr_o, 0);
        checkOutput({tag, "_valid"}, valid_o, 0);
        checkOutput({tag, "_data"}, data_o, 0);
    endtask

    initial begin
        int beats;
        int dones;
        logic rdy;
        logic hold_prev;
        logic [255:0] data_prev;
        logic done_seen;

        n_assert    = 0;
        n_fail      = 0;
        nrst        = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        stride_i    = '0;
        count_i     = '0;
        ready_i     = 1'b0;

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkZero("reset");
        nrst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] basic transfer, ready held high");
        applyStimulus(1, 32'h40, 32, 4, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput("t1_rd_en", rd_en_o, (k >= 1 && k <= 4));
            if (k <= 4) checkOutput("t1_rd_addr", rd_addr_o, 32'h40 + 32 * (k - 1));
            if (k == 5) checkOutput("t1_rd_addr_hold", rd_addr_o, 32'hA0);
            checkOutput("t1_valid", valid_o, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) checkOutput("t1_data", data_o, pat(32'h40 + 32 * (k - 3)));
            checkOutput("t1_done", done_o, (k == 7));
            checkOutput("t1_busy", busy_o, (k <= 6));
        end

        $display("[TB] back-pressure stall");
        beats = 0;
        applyStimulus(1, 32'h40, 32, 4, 1);
        for (int k = 1; k <= 18; k++) begin
            rdy = !(k >= 2 && k <= 10);
            applyStimulus(0, 0, 0, 0, rdy);
            if (k <= 10) checkOutput("t2_rd_en", rd_en_o, (k == 1 || k == 2));
            if (k >= 3 && k <= 10) begin
                checkOutput("t2_valid_held", valid_o, 1);
                checkOutput("t2_data_held", data_o, pat(32'h40));
            end
            if (valid_o && ready_i) begin
                checkOutput("t2_beat", data_o, pat(32'h40 + 32 * beats));
                beats++;
            end
            checkOutput("t2_done", done_o, (k == 15));
        end
        checkOutput("t2_beat_total", beats, 4);

        $display("[TB] zero-length transfer");
        applyStimulus(1, 32'h80, 32, 0, 1);
        checkOutput("t3_busy_s", busy_o, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput("t3_done", done_o, (k == 1));
            checkOutput("t3_busy", busy_o, 0);
            checkOutput("t3_rd_en", rd_en_o, 0);
        end

        $display("[TB] address wrap");
        applyStimulus(1, 32'hFFFF_FFE0, 32, 3, 1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (k == 1) checkOutput("t4_addr0", rd_addr_o, 32'hFFFF_FFE0);
            if (k == 2) checkOutput("t4_addr1", rd_addr_o, 32'h0000_0000);
            if (k == 3) checkOutput("t4_addr2", rd_addr_o, 32'h0000_0020);
            if (k <= 3) checkOutput("t4_rd_en", rd_en_o, 1);
            if (k == 3) checkOutput("t4_data0", data_o, pat(32'hFFFF_FFE0));
            if (k == 4) checkOutput("t4_data1", data_o, pat(32'h0000_0000));
            if (k == 5) checkOutput("t4_data2", data_o, pat(32'h0000_0020));
        end

        $display("[TB] restart in done cycle, then reset mid-transfer");
        applyStimulus(1, 32'h300, 64, 4, 1);
        checkOutput("t5_done_at_restart", done_o, 1);
        checkOutput("t5_busy_at_restart", busy_o, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5_pre_rd_en", rd_en_o, 1);
        checkOutput("t5_pre_fifo", dut.fifo_cnt, 1);
        checkOutput("t5_pre_inflight", dut.inflight, 1);
        nrst = 1'b0;
        #1;
        checkZero("t5_async");
        applyStimulus(0, 0, 0, 0, 1);
        checkZero("t5_held");
        checkOutput("t5_fifo_clr", dut.fifo_cnt, 0);
        checkOutput("t5_inflight_clr", dut.inflight, 0);
        nrst = 1'b1;
        beats = 0;
        dones = 0;
        applyStimulus(1, 32'h500, 32, 2, 1);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (valid_o && ready_i) begin
                checkOutput("t5_beat", data_o, pat(32'h500 + 32 * beats));
                beats++;
            end
            checkOutput("t5_done", done_o, (k == 5));
        end
        checkOutput("t5_beat_total", beats, 2);

        $display("[TB] random ready, 200 beats");
        beats     = 0;
        dones     = 0;
        hold_prev = 1'b0;
        data_prev = '0;
        done_seen = 1'b0;
        applyStimulus(1, 32'h1000, 64, 200, 1);
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)));
            checkOutput("t6_fifo_le2", (dut.fifo_cnt <= 2), 1);
            if (hold_prev) begin
                checkOutput("t6_valid_stable", valid_o, 1);
                checkOutput("t6_data_stable", data_o, data_prev);
            end
            if (valid_o && ready_i) begin
                checkOutput("t6_beat", data_o, pat(32'h1000 + 64 * beats));
                beats++;
            end
            if (done_o) begin
                dones++;
                done_seen = 1'b1;
            end
            hold_prev = valid_o && !ready_i;
            data_prev = data_o;
        end
        checkOutput("t6_done_seen", done_seen, 1);
        checkOutput("t6_beat_total", beats, 200);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (done_o) dones++;
        end
        checkOutput("t6_done_count", dones, 1);
        checkOutput("t6_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
